// File: rtl/id_md_sched.sv
`default_nettype none
// ============================================================================
//  Module   : id_md_sched
//  Purpose  : ID-stage issue scheduler for the multi-cycle multiply/divide
//             unit and the HI/LO registers. Decodes SPECIAL-opcode
//             instructions, starts MULT/MULTU/DIV/DIVU, times the unit's
//             busy/done window with a down-counter and stalls any HI/LO
//             access that would race an in-flight operation.
//  Ports    :
//     clk            in   system clock, rising edge
//     resetn         in   asynchronous active-low reset
//     id_valid       in   ID holds a valid instruction
//     id_inst[31:0]  in   instruction in ID
//     ex_allowin     in   EX can accept an instruction this cycle
//     flush          in   exception/eret flush of ID and younger stages
//     id_stall       out  ID must hold its instruction
//     id_to_ex_valid out  ID instruction advances to EX this cycle
//     md_start       out  one-cycle start pulse to the mul/div unit
//     md_op[1:0]     out  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     md_rs[4:0]     out  source A register index
//     md_rt[4:0]     out  source B register index
//     md_busy        out  operation in flight, HI/LO not yet final
//     md_done        out  one-cycle pulse, HI/LO written at end of cycle
//  Revision : 1.0  initial release
// ============================================================================
module id_md_sched #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 33,
   parameter int CNT_W      = 6
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        id_valid,
   input  logic [31:0] id_inst,
   input  logic        ex_allowin,
   input  logic        flush,
   output logic        id_stall,
   output logic        id_to_ex_valid,
   output logic        md_start,
   output logic [1:0]  md_op,
   output logic [4:0]  md_rs,
   output logic [4:0]  md_rt,
   output logic        md_busy,
   output logic        md_done
);

   localparam logic [5:0]       C_OP_SPECIAL = 6'h00;
   // funct[5:2] groups: 0x18..0x1B mul/div, 0x10..0x13 MFHI/MTHI/MFLO/MTLO
   localparam logic [3:0]       C_FN_MD      = 4'b0110;
   localparam logic [3:0]       C_FN_HILO    = 4'b0100;
   localparam logic [CNT_W-1:0] C_MUL_LOAD   = CNT_W'(MUL_CYCLES);
   localparam logic [CNT_W-1:0] C_DIV_LOAD   = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_CNT_ZERO   = '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   logic [5:0] w_opcode;
   logic [5:0] w_funct;
   logic       w_is_special;
   logic       w_is_md;
   logic       w_is_hilo;
   logic       w_issue;
   logic       w_unused_bits;

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   assign w_opcode     = id_inst[31:26];
   assign w_funct      = id_inst[5:0];
   assign w_is_special = (w_opcode == C_OP_SPECIAL);
   assign w_is_md      = w_is_special & (w_funct[5:2] == C_FN_MD);
   assign w_is_hilo    = w_is_md | (w_is_special & (w_funct[5:2] == C_FN_HILO));

   // Shift amount / rd fields play no part in scheduling.
   assign w_unused_bits = ^id_inst[15:6];

   // ------------------------------------------------------------------
   // Handshake and stall
   // ------------------------------------------------------------------
   assign md_busy        = (r_state != ST_IDLE);
   assign md_done        = (r_state == ST_DONE);
   assign id_stall       = id_valid & w_is_hilo & md_busy;
   assign id_to_ex_valid = id_valid & ex_allowin & ~id_stall & ~flush;

   // A mul/div can only get here with the unit idle, because it is itself
   // a HI/LO instruction and would otherwise be stalled. The resetn term
   // keeps a start pulse from escaping while the block is held in reset.
   assign w_issue  = id_to_ex_valid & w_is_md & resetn;
   assign md_start = w_issue;
   assign md_op    = w_funct[1:0];
   assign md_rs    = id_inst[25:21];
   assign md_rt    = id_inst[20:16];

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_cnt   <= C_CNT_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next state / counter
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_issue) begin
               // funct[1] separates DIV/DIVU from MULT/MULTU
               w_cnt_nxt   = w_funct[1] ? C_DIV_LOAD : C_MUL_LOAD;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // The <= guard also covers a zero count so the counter can
            // never underflow into a huge wait.
            if (r_cnt <= C_CNT_ONE) begin
               w_cnt_nxt   = C_CNT_ZERO;
               w_state_nxt = ST_DONE;
            end else begin
               w_cnt_nxt = r_cnt - C_CNT_ONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = C_CNT_ZERO;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_id_md_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_md_sched
//  Purpose  : Self-checking bench for id_md_sched. A stimulus process drives
//             directed and random instruction streams and pushes the expected
//             per-cycle response, computed from a timeline model (cycle in
//             which the in-flight operation completes), into a queue; a
//             monitor pops and compares on the falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_md_sched;

   localparam int MUL_CYCLES = 4;
   localparam int DIV_CYCLES = 33;
   localparam int CNT_W      = 6;

   localparam logic [31:0] I_MULT  = 32'h00850018;
   localparam logic [31:0] I_DIV   = 32'h0085001A;
   localparam logic [31:0] I_DIVU  = 32'h0085001B;
   localparam logic [31:0] I_MFLO  = 32'h00001012;
   localparam logic [31:0] I_ADDU  = 32'h00221821;
   localparam logic [31:0] I_NOP   = 32'h00000000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        id_valid;
   logic [31:0] id_inst;
   logic        ex_allowin;
   logic        flush;
   logic        id_stall;
   logic        id_to_ex_valid;
   logic        md_start;
   logic [1:0]  md_op;
   logic [4:0]  md_rs;
   logic [4:0]  md_rt;
   logic        md_busy;
   logic        md_done;

   id_md_sched #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .id_valid       (id_valid),
      .id_inst        (id_inst),
      .ex_allowin     (ex_allowin),
      .flush          (flush),
      .id_stall       (id_stall),
      .id_to_ex_valid (id_to_ex_valid),
      .md_start       (md_start),
      .md_op          (md_op),
      .md_rs          (md_rs),
      .md_rt          (md_rt),
      .md_busy        (md_busy),
      .md_done        (md_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       stall;
      logic       itev;
      logic       start;
      logic       busy;
      logic       done;
      logic [1:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   done_at = -1;   // cycle in which the in-flight operation pulses done
   logic m_itev  = 1'b0;

   function automatic logic f_is_md(input logic [31:0] i);
      return (i[31:26] == 6'h00) && (i[5:0] >= 6'h18) && (i[5:0] <= 6'h1B);
   endfunction

   function automatic logic f_is_hilo(input logic [31:0] i);
      return f_is_md(i) ||
             ((i[31:26] == 6'h00) && (i[5:0] >= 6'h10) && (i[5:0] <= 6'h13));
   endfunction

   task automatic chk(input string n, input int c, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h required %0h", n, c, act, req);
      end
   endtask

   // One clock of stimulus plus the model's expectation for that clock.
   task automatic drive(input logic v, input logic [31:0] inst, input logic allow,
                        input logic fl, input logic rn);
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      id_valid   = v;
      id_inst    = inst;
      ex_allowin = allow;
      flush      = fl;
      resetn     = rn;
      if (!rn) done_at = -1;
      e.cyc   = cyc;
      e.busy  = (done_at >= cyc);
      e.done  = (done_at == cyc);
      e.stall = v && f_is_hilo(inst) && e.busy;
      e.itev  = v && allow && !e.stall && !fl;
      e.start = e.itev && f_is_md(inst) && rn;
      e.op    = inst[1:0];
      e.rs    = inst[25:21];
      e.rt    = inst[20:16];
      if (e.start) done_at = cyc + (inst[1] ? DIV_CYCLES : MUL_CYCLES) + 1;
      m_itev = e.itev;
      q.push_back(e);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 4))
         0: begin r[31:26] = 6'h00; r[5:0] = 6'h18 + 6'($urandom_range(0, 3)); end
         1: begin r[31:26] = 6'h00; r[5:0] = 6'h10 + 6'($urandom_range(0, 3)); end
         2: r[31:26] = 6'h00;
         3: begin
            case ($urandom_range(0, 2))
               0:       r[31:26] = 6'h23;
               1:       r[31:26] = 6'h2B;
               default: r[31:26] = 6'h04;
            endcase
         end
         default: ;
      endcase
      return r;
   endfunction

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("id_stall",       e.cyc, 32'(id_stall),       32'(e.stall));
            chk("id_to_ex_valid", e.cyc, 32'(id_to_ex_valid), 32'(e.itev));
            chk("md_start",       e.cyc, 32'(md_start),       32'(e.start));
            chk("md_busy",        e.cyc, 32'(md_busy),        32'(e.busy));
            chk("md_done",        e.cyc, 32'(md_done),        32'(e.done));
            if (e.start) begin
               chk("md_op", e.cyc, 32'(md_op), 32'(e.op));
               chk("md_rs", e.cyc, 32'(md_rs), 32'(e.rs));
               chk("md_rt", e.cyc, 32'(md_rt), 32'(e.rt));
            end
         end
      end
   end

   // Stimulus
   initial begin
      int          adv_k;
      logic [31:0] cur;
      logic        hold;
      resetn     = 1'b0;
      id_valid   = 1'b1;
      id_inst    = I_MULT;
      ex_allowin = 1'b1;
      flush      = 1'b0;

      // Reset held with a MULT sitting in ID, then released.
      repeat (3) drive(1'b1, I_MULT, 1'b1, 1'b0, 1'b0);
      drive(1'b1, I_MULT, 1'b1, 1'b0, 1'b1);
      repeat (7) drive(1'b1, I_NOP, 1'b1, 1'b0, 1'b1);

      // DIVU followed by MFLO held until it advances.
      drive(1'b1, I_DIVU, 1'b1, 1'b0, 1'b1);
      adv_k = -1;
      for (int k = 0; k < 60; k++) begin
         drive(1'b1, I_MFLO, 1'b1, 1'b0, 1'b1);
         if (m_itev) begin
            adv_k = k;
            break;
         end
      end
      chk("mflo_advance_offset", cyc, 32'(adv_k), 32'(DIV_CYCLES + 1));
      repeat (2) drive(1'b1, I_NOP, 1'b1, 1'b0, 1'b1);

      // Independent instruction during a divide.
      drive(1'b1, I_DIV, 1'b1, 1'b0, 1'b1);
      drive(1'b1, I_ADDU, 1'b1, 1'b0, 1'b1);
      repeat (36) drive(1'b1, I_NOP, 1'b1, 1'b0, 1'b1);

      // EX back-pressure and flush while idle.
      repeat (2) drive(1'b1, I_MULT, 1'b0, 1'b0, 1'b1);
      drive(1'b1, I_MULT, 1'b1, 1'b1, 1'b1);
      // Flush mid-run must not disturb the in-flight multiply.
      drive(1'b1, I_MULT, 1'b1, 1'b0, 1'b1);
      drive(1'b1, I_NOP, 1'b1, 1'b1, 1'b1);
      drive(1'b1, I_MULT, 1'b1, 1'b1, 1'b1);
      repeat (5) drive(1'b1, I_NOP, 1'b1, 1'b0, 1'b1);

      // Reset mid-divide, then an immediate MULT.
      drive(1'b1, I_DIV, 1'b1, 1'b0, 1'b1);
      repeat (9) drive(1'b1, I_NOP, 1'b1, 1'b0, 1'b1);
      repeat (2) drive(1'b1, I_NOP, 1'b1, 1'b0, 1'b0);
      drive(1'b1, I_MULT, 1'b1, 1'b0, 1'b1);
      repeat (40) drive(1'b1, I_NOP, 1'b1, 1'b0, 1'b1);

      // Randomized traffic.
      cur  = rand_inst();
      hold = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         logic v, al, fl, rn;
         if (!(hold && ($urandom_range(0, 9) < 7))) cur = rand_inst();
         v  = ($urandom_range(0, 99) < 85);
         al = ($urandom_range(0, 99) < 80);
         fl = ($urandom_range(0, 19) == 0);
         rn = ($urandom_range(0, 199) != 0);
         drive(v, cur, al, fl, rn);
         hold = v && !m_itev && !fl;
      end

      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/id_md_sched.md
Name: id_md_sched

Overview:
- Issue scheduler for the multi-cycle multiply/divide unit and the HI/LO registers, placed in the ID stage.
- Decodes the SPECIAL-opcode fields of the ID instruction and decides when a MULT/MULTU/DIV/DIVU may start.
- Sequences the unit's busy/done timing with a down-counter.
- Stalls ID when a HI/LO-touching instruction would conflict with an in-flight operation; all other instructions pass unimpeded.

Parameters:
- MUL_CYCLES, 4, execution cycles for MULT/MULTU (1..2^CNT_W-1)
- DIV_CYCLES, 33, execution cycles for DIV/DIVU (1..2^CNT_W-1)
- CNT_W, 6, counter width

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_inst  in  32  instruction in ID
- ex_allowin  in  1  EX can accept an instruction this cycle
- flush  in  1  exception/eret flush of ID and younger stages
- id_stall  out  1  ID must hold its instruction
- id_to_ex_valid  out  1  ID instruction advances to EX this cycle
- md_start  out  1  one-cycle start pulse to the mul/div unit
- md_op  out  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; valid with md_start
- md_rs  out  5  id_inst[25:21], source A register index
- md_rt  out  5  id_inst[20:16], source B register index
- md_busy  out  1  operation in flight; HI/LO not yet final
- md_done  out  1  one-cycle pulse; unit writes HI/LO at end of this cycle

Behaviour:
Decode (combinational), with opcode=id_inst[31:26] and funct=id_inst[5:0]:
- is_md: opcode==0 and funct in {0x18,0x19,0x1A,0x1B}.
- is_hilo: is_md, or opcode==0 and funct in {0x10,0x11,0x12,0x13} (MFHI, MTHI, MFLO, MTLO).
- md_op = funct[1:0].

FSM states: IDLE, RUN, DONE. Reset: IDLE, cnt=0, md_done=0.
- md_busy = (state != IDLE).
- id_stall = id_valid & is_hilo & md_busy.
- id_to_ex_valid = id_valid & ex_allowin & ~id_stall & ~flush.
- issue = id_to_ex_valid & is_md. This implies state==IDLE.
- md_start = issue (combinational, same cycle as the handshake).
- IDLE:
  - on issue, load cnt with DIV_CYCLES when funct[1]=1, else MUL_CYCLES; go to RUN.
  - otherwise stay in IDLE.
- RUN:
  - cnt decrements by 1 each cycle.
  - when cnt==1, go to DONE; cnt becomes 0.
- DONE:
  - md_done=1 (registered, high only while in DONE).
  - unconditionally return to IDLE next cycle.

Timing, issue in cycle N:
- md_busy high N+1 .. N+L+1 (L = configured cycles).
- md_done high in N+L+1.
- Earliest next issue, and earliest unstalled MFHI/MFLO/MTHI/MTLO, is N+L+2.

Boundary conditions:
- ex_allowin=0: no issue and no state change from ID. The instruction is not stalled by this block, but id_to_ex_valid=0.
- flush=1: suppresses issue and id_to_ex_valid in that cycle. An already-issued operation is older than the flushed instruction, so it continues to md_done unaffected.
- flush in the same cycle as a would-be issue: no md_start and state stays IDLE.
- Non-HI/LO instructions (including loads, stores, branches) never stall here, even while busy.
- An instruction presented during DONE that touches HI/LO stalls. DONE is still busy.
- id_valid=0: decode outputs are don't-care for control; id_stall=0, md_start=0.
- resetn low at any time, including mid-RUN: immediately IDLE, cnt=0, md_done=0, md_busy=0; no md_done pulse is produced for the aborted operation.
- Counter never wraps: loads are ≥1 and it only decrements in RUN while cnt≥1.

Test Plan:
- Reset: hold resetn=0 with id_valid=1, id_inst=0x00850018 → md_busy=0, md_done=0, md_start=0. Release resetn, ex_allowin=1 → md_start=1, md_op=00, md_rs=4, md_rt=5 in the first cycle.
- MULT latency: issue 0x00850018 at cycle N (MUL_CYCLES=4) → md_busy N+1..N+5, md_done only at N+5, state IDLE at N+6.
- DIVU then MFLO: issue 0x0085001B at N, then present 0x00001012 → md_op=11, id_stall=1 and id_to_ex_valid=0 for N+1..N+34, advances at N+35.
- Independent instruction during a divide: present ADDU 0x00221821 at N+1 while busy → id_stall=0, id_to_ex_valid=1, no md_start.
- Flush: assert flush with MULT in ID and IDLE → no md_start, state stays IDLE. Assert flush mid-RUN → md_done still pulses at the scheduled cycle.
- Reset mid-operation: drop resetn at N+10 of a DIV → md_busy falls asynchronously. After release, no md_done pulse occurs and a new MULT issues immediately.
